aib_stripe_gather: RTL

- Parametrised word-to-flit striping and reassembly engine between the UMAI protocol layer and a configurable range of AIB channels.
- TX: accepts wide words, splits them into flits and distributes the flits round-robin over active channels [first..last], with a per-channel FIFO.
- RX: collects flits from the same channel pattern and rebuilds words.
- Generalises the fixed one-flit-per-channel binding to a runtime-selectable channel range and an arbitrary flits-per-word ratio.

---
 rtl/aib_stripe_gather_if.sv | 42 ++++
 rtl/aib_stripe_gather.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/aib_stripe_gather_if.sv
// Bus bundle for aib_stripe_gather: config, TX word/flit and RX flit/word handshakes.
// The slave modport is the engine's view; the master modport is the driving side.
interface aib_stripe_gather_if #(
  parameter int NumChannels  = 6,
  parameter int FlitWidth    = 72,
  parameter int FlitsPerWord = 8
);
  localparam int CW = $clog2(NumChannels);
  localparam int W  = FlitsPerWord * FlitWidth;

  logic [CW-1:0]                         c_first_chn_id;
  logic [CW-1:0]                         c_last_chn_id;
  logic                                  o_cfg_err;
  logic                                  i_tx_word_valid;
  logic                                  o_tx_word_ready;
  logic [W-1:0]                          i_tx_word;
  logic [NumChannels-1:0]                o_tx_valid;
  logic [NumChannels-1:0]                i_tx_ready;
  logic [NumChannels-1:0][FlitWidth-1:0] o_tx_data;
  logic [NumChannels-1:0]                i_rx_valid;
  logic [NumChannels-1:0]                o_rx_ready;
  logic [NumChannels-1:0][FlitWidth-1:0] i_rx_data;
  logic                                  o_rx_word_valid;
  logic                                  i_rx_word_ready;
  logic [W-1:0]                          o_rx_word;
  logic                                  o_tx_busy;
  logic                                  o_rx_busy;

  modport slave (
    input  c_first_chn_id, c_last_chn_id, i_tx_word_valid, i_tx_word, i_tx_ready,
           i_rx_valid, i_rx_data, i_rx_word_ready,
    output o_cfg_err, o_tx_word_ready, o_tx_valid, o_tx_data, o_rx_ready,
           o_rx_word_valid, o_rx_word, o_tx_busy, o_rx_busy
  );

  modport master (
    output c_first_chn_id, c_last_chn_id, i_tx_word_valid, i_tx_word, i_tx_ready,
           i_rx_valid, i_rx_data, i_rx_word_ready,
    input  o_cfg_err, o_tx_word_ready, o_tx_valid, o_tx_data, o_rx_ready,
           o_rx_word_valid, o_rx_word, o_tx_busy, o_rx_busy
  );
endinterface

// File: rtl/aib_stripe_gather.sv
// Word-to-flit striping over AIB channels [first..last] with per-channel FWFT TX FIFOs,
// and the matching round-robin RX gather that rebuilds words.
module aib_stripe_gather #(
  parameter int NumChannels  = 6,
  parameter int FlitWidth    = 72,
  parameter int FlitsPerWord = 8,
  parameter int FifoDepth    = 4,
  parameter int CW           = $clog2(NumChannels)
) (
  input logic i_clk,
  input logic i_rst,
  aib_stripe_gather_if.slave bus
);
  localparam int W  = FlitsPerWord * FlitWidth;
  localparam int IW = $clog2(FlitsPerWord);
  localparam int PW = $clog2(FifoDepth);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic cfg_err;
  assign cfg_err = (bus.c_last_chn_id < bus.c_first_chn_id) ||
                   (int'(bus.c_last_chn_id) >= NumChannels);
  assign bus.o_cfg_err = cfg_err;

  tx_state_t                             tx_state, tx_state_nxt;
  logic [W-1:0]                          tx_word_q;
  logic [CW-1:0]                         tx_first, tx_last, tx_ptr, tx_ptr_nxt;
  logic [IW-1:0]                         tx_idx, tx_idx_nxt;
  logic                                  tx_accept, push;
  logic [FlitWidth-1:0]                  push_data;
  logic [NumChannels-1:0]                fifo_full, tx_valid, rx_ready;
  logic [NumChannels-1:0][FlitWidth-1:0] tx_data;

  assign push_data = tx_word_q[tx_idx*FlitWidth +: FlitWidth];

  // A full FIFO at the current pointer stalls the word; channels are never skipped.
  always_comb begin
    tx_state_nxt        = tx_state;
    tx_ptr_nxt          = tx_ptr;
    tx_idx_nxt          = tx_idx;
    tx_accept           = 1'b0;
    push                = 1'b0;
    bus.o_tx_word_ready = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        bus.o_tx_word_ready = !cfg_err && !i_rst;
        if (bus.i_tx_word_valid && !cfg_err && !i_rst) begin
          tx_accept    = 1'b1;
          tx_state_nxt = TX_SEND;
          tx_idx_nxt   = '0;
          tx_ptr_nxt   = bus.c_first_chn_id;
        end
      end
      TX_SEND: begin
        if (!fifo_full[tx_ptr]) begin
          push       = 1'b1;
          tx_idx_nxt = tx_idx + IW'(1);
          tx_ptr_nxt = (tx_ptr == tx_last) ? tx_first : tx_ptr + CW'(1);
          if (tx_idx == IW'(FlitsPerWord - 1)) tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state  <= TX_IDLE;
      tx_ptr    <= '0;
      tx_idx    <= '0;
      tx_first  <= '0;
      tx_last   <= '0;
      tx_word_q <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_ptr   <= tx_ptr_nxt;
      tx_idx   <= tx_idx_nxt;
      if (tx_accept) begin
        tx_word_q <= bus.i_tx_word;
        tx_first  <= bus.c_first_chn_id;
        tx_last   <= bus.c_last_chn_id;
      end
    end
  end

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_fifo
    logic [FlitWidth-1:0] mem [FifoDepth];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 push_ch, pop_ch;

    assign push_ch       = push && (tx_ptr == CW'(ch));
    assign pop_ch        = tx_valid[ch] && bus.i_tx_ready[ch];
    assign fifo_full[ch] = (count == (PW+1)'(FifoDepth));
    assign tx_valid[ch]  = (count != '0);
    assign tx_data[ch]   = tx_valid[ch] ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
      if (push_ch) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ch) wr_ptr <= wr_ptr + PW'(1);
        if (pop_ch)  rd_ptr <= rd_ptr + PW'(1);
        if (push_ch && !pop_ch)      count <= count + (PW+1)'(1);
        else if (pop_ch && !push_ch) count <= count - (PW+1)'(1);
      end
    end
  end

  assign bus.o_tx_valid = tx_valid;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_busy  = (tx_state == TX_SEND) || (|tx_valid);

  logic [CW-1:0] rx_first_q, rx_last_q, rx_ptr_q, rx_first, rx_last, rx_ptr;
  logic [IW-1:0] rx_idx;
  logic          rx_pending, rx_idle, rx_open, rx_accept;
  logic [W-1:0]  rx_buf;

  // Between words the gather follows the live config; it freezes once a word has started.
  assign rx_idle   = (rx_idx == '0) && !rx_pending;
  assign rx_first  = rx_idle ? bus.c_first_chn_id : rx_first_q;
  assign rx_last   = rx_idle ? bus.c_last_chn_id  : rx_last_q;
  assign rx_ptr    = rx_idle ? bus.c_first_chn_id : rx_ptr_q;
  assign rx_open   = !rx_pending && !i_rst && (!rx_idle || !cfg_err);
  assign rx_accept = rx_open && bus.i_rx_valid[rx_ptr];

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_rx_ready
    assign rx_ready[ch] = rx_open && (rx_ptr == CW'(ch));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_first_q <= '0;
      rx_last_q  <= '0;
      rx_ptr_q   <= '0;
      rx_idx     <= '0;
      rx_pending <= 1'b0;
      rx_buf     <= '0;
    end else if (rx_accept) begin
      rx_buf[rx_idx*FlitWidth +: FlitWidth] <= bus.i_rx_data[rx_ptr];
      rx_first_q <= rx_first;
      rx_last_q  <= rx_last;
      rx_ptr_q   <= (rx_ptr == rx_last) ? rx_first : rx_ptr + CW'(1);
      if (rx_idx == IW'(FlitsPerWord - 1)) begin
        rx_idx     <= '0;
        rx_pending <= 1'b1;
      end else begin
        rx_idx <= rx_idx + IW'(1);
      end
    end else if (rx_pending && bus.i_rx_word_ready) begin
      rx_pending <= 1'b0;
      rx_ptr_q   <= rx_first_q;
    end
  end

  assign bus.o_rx_ready      = rx_ready;
  assign bus.o_rx_word_valid = rx_pending;
  assign bus.o_rx_word       = rx_buf;
  assign bus.o_rx_busy       = rx_pending || (rx_idx != '0);
endmodule
